// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle data-processing ops plus a 32-iteration shift-add MUL.
// Result and NZCV flags are registered; Done pulses for one cycle on every completion.
module alu_exec_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] Shifted,
  input  logic [3:0]       ALUControl,
  input  logic             SetFlags,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             Done,
  output logic             Busy
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sf_q, sf_d;

  logic             accept, mul_last;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] add_x, add_y, op_res;
  logic             add_cin, is_arith, is_defined;
  logic [WIDTH:0]   sum;
  logic             add_v;

  assign accept   = Start && (state_q == StIdle);
  assign mul_last = (cnt_q == CntLast);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Subtracts are folded into one adder as X + ~Y + 1.
  always_comb begin
    add_x   = SrcA;
    add_y   = Shifted;
    add_cin = 1'b0;
    unique case (ALUControl)
      4'b0010, 4'b1010: begin add_y = ~Shifted; add_cin = 1'b1; end
      4'b0011: begin add_x = Shifted; add_y = ~SrcA; add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    op_res     = '0;
    is_arith   = 1'b0;
    is_defined = 1'b1;
    case (ALUControl)
      4'b0000: op_res = SrcA & Shifted;
      4'b0001: op_res = SrcA ^ Shifted;
      4'b0010, 4'b0011, 4'b0100, 4'b1010: begin
        op_res   = sum[WIDTH-1:0];
        is_arith = 1'b1;
      end
      4'b1100: op_res = SrcA | Shifted;
      4'b1101: op_res = Shifted;
      4'b1110: op_res = SrcA & ~Shifted;
      4'b1111: op_res = ~Shifted;
      default: is_defined = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && ALUControl == 4'b1001) state_d = StMul;
      StMul:  if (mul_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    Busy   = (state_q == StMul);
    Result = result_q;
    Flags  = flags_q;
    Done   = done_q;
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sf_d     = sf_q;
    if (state_q == StMul) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (mul_last) begin
        result_d = acc_step;
        done_d   = 1'b1;
        if (sf_q) flags_d = {acc_step[WIDTH-1], acc_step == '0, flags_q[1:0]};
      end
    end else if (accept) begin
      if (ALUControl == 4'b1001) begin
        acc_d    = '0;
        mcand_d  = SrcA;
        mplier_d = Shifted;
        cnt_d    = '0;
        sf_d     = SetFlags;
      end else begin
        result_d = op_res;
        done_d   = 1'b1;
        if (SetFlags && is_defined) begin
          flags_d = is_arith ? {op_res[WIDTH-1], op_res == '0, sum[WIDTH], add_v}
                             : {op_res[WIDTH-1], op_res == '0, flags_q[1:0]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sf_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sf_q     <= sf_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [31:0] SrcA, Shifted;
  logic [3:0]  ALUControl;
  logic        SetFlags;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic        Done, Busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_res   = '0;
  logic [3:0]  m_flags = '0;

  alu_exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Start      (Start),
    .SrcA       (SrcA),
    .Shifted    (Shifted),
    .ALUControl (ALUControl),
    .SetFlags   (SetFlags),
    .Result     (Result),
    .Flags      (Flags),
    .Done       (Done),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic sf);
    logic [31:0] r;
    logic [32:0] wide;
    longint      s;
    logic        c, v;
    bit          arith, def;
    r = '0; c = 1'b0; v = 1'b0; s = 0; arith = 0; def = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a ^ b;
      4'h2, 4'hA: begin
        wide = {1'b0, a} - {1'b0, b}; r = wide[31:0]; c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b)); arith = 1;
      end
      4'h3: begin
        wide = {1'b0, b} - {1'b0, a}; r = wide[31:0]; c = (b >= a);
        s = longint'($signed(b)) - longint'($signed(a)); arith = 1;
      end
      4'h4: begin
        wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32];
        s = longint'($signed(a)) + longint'($signed(b)); arith = 1;
      end
      4'h9: r = a * b;
      4'hC: r = a | b;
      4'hD: r = b;
      4'hE: r = a & ~b;
      4'hF: r = ~b;
      default: def = 0;
    endcase
    if (arith) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    m_res = r;
    if (def && sf) m_flags = arith ? {r[31], r == 0, c, v} : {r[31], r == 0, m_flags[1:0]};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sf, input bit inject);
    logic [31:0] old_res;
    logic [3:0]  old_flags;
    old_res   = m_res;
    old_flags = m_flags;
    ref_op(op, a, b, sf);
    @(negedge clk);
    Start = 1'b1; SrcA = a; Shifted = b; ALUControl = op; SetFlags = sf;
    @(posedge clk); #1;
    // Scramble inputs to confirm they were captured at acceptance.
    Start = 1'b0; SrcA = $urandom; Shifted = $urandom;
    ALUControl = 4'($urandom); SetFlags = 1'($urandom);
    if (op == 4'h9) begin
      chk("mul_busy_k", Busy, 1);
      chk("mul_done_k", Done, 0);
      chk("mul_hold_k", Result, old_res);
      for (int i = 1; i <= 31; i++) begin
        @(negedge clk);
        if (inject && (i == 5 || i == 31)) begin
          Start = 1'b1; ALUControl = 4'h4; SrcA = 32'h1; Shifted = 32'h2;
        end
        @(posedge clk); #1;
        Start = 1'b0;
        chk("mul_busy", Busy, 1);
        chk("mul_done_early", Done, 0);
        if (i == 5 || i == 31) begin
          chk("mul_hold_res", Result, old_res);
          chk("mul_hold_flags", {28'b0, Flags}, {28'b0, old_flags});
        end
      end
      @(negedge clk);
      @(posedge clk); #1;
      chk("mul_busy_end", Busy, 0);
      chk("mul_done", Done, 1);
    end else begin
      chk("op_done", Done, 1);
      chk("op_busy", Busy, 0);
    end
    chk("result", Result, m_res);
    chk("flags", {28'b0, Flags}, {28'b0, m_flags});
  endtask

  task automatic idle_check();
    @(negedge clk);
    Start = 1'b0;
    @(posedge clk); #1;
    chk("done_fall", Done, 0);
    chk("idle_hold", Result, m_res);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; Start = 1'b0; SrcA = '0; Shifted = '0; ALUControl = '0; SetFlags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", Result, 0);
    chk("rst_flags", {28'b0, Flags}, 0);
    chk("rst_done", Done, 0);
    chk("rst_busy", Busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    run_op(4'h4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0);
    chk("add_flags_1001", {28'b0, Flags}, 32'h9);
    idle_check();
    run_op(4'h2, 32'd5, 32'd5, 1'b1, 0);
    chk("sub_flags_0110", {28'b0, Flags}, 32'h6);
    run_op(4'h3, 32'd6, 32'd5, 1'b1, 0);
    chk("rsb_res", Result, 32'hFFFF_FFFF);
    run_op(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    chk("mul_ones", Result, 32'h1);
    run_op(4'h9, 32'd12, 32'd10, 1'b1, 1);
    chk("mul_120", Result, 32'd120);
    idle_check();
    run_op(4'hA, 32'd3, 32'd7, 1'b1, 0);
    run_op(4'hC, 32'hF0F0_0000, 32'h0000_000F, 1'b0, 0);
    chk("orr_res", Result, 32'hF0F0_000F);
    run_op(4'h7, 32'h1234, 32'h5678, 1'b1, 0);

    // Reset mid-MUL: aborts with no later Done
    run_op(4'h4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0);
    @(negedge clk);
    Start = 1'b1; SrcA = 32'd9; Shifted = 32'd9; ALUControl = 4'h9; SetFlags = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_result", Result, 0);
    chk("rst_mid_flags", {28'b0, Flags}, 0);
    chk("rst_mid_busy", Busy, 0);
    m_res = '0; m_flags = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      chk("rst_no_done", Done, 0);
    end

    // Randomized back-to-back traffic
    for (int n = 0; n < 150; n++) begin
      run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 1'($urandom),
             bit'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic/logic unit that sits directly downstream of the operand shifter. It consumes register operand A and the shifter's `Shifted` operand B, and produces a registered 32-bit result plus a registered NZCV flag set. Data-processing ops complete in one cycle. MUL runs as a 32-cycle iterative shift-add sequence behind a Start/Busy/Done handshake.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `MUL_CYCLES`, 32: number of MUL iterations. Must equal `WIDTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request strobe; sampled on each rising edge.
- `SrcA`  in  32  operand A (register Rn).
- `Shifted`  in  32  operand B (shifter output).
- `ALUControl`  in  4  operation select.
- `SetFlags`  in  1  update `Flags` when the operation completes.
- `Result`  out  32  registered result.
- `Flags`  out  4  registered {N,Z,C,V}.
- `Done`  out  1  one-cycle pulse: `Result`/`Flags` updated.
- `Busy`  out  1  MUL in progress; `Start` is ignored while high.

## Operation
- Opcodes:
  - 0000 AND, 0001 EOR, 0010 SUB (A−B), 0011 RSB (B−A), 0100 ADD, 1010 CMP (A−B), 1100 ORR, 1101 MOV (B), 1110 BIC (A & ~B), 1111 MVN (~B).
  - 1001 MUL: low 32 bits of A×B, unsigned. The low word is sign-independent.
  - Any other code is undefined: `Result`=0, `Flags` unchanged, `Done` still pulses.
- Request acceptance: a request is accepted on an edge where `Start`=1 and `Busy`=0. `SrcA`, `Shifted` and `ALUControl` are captured at that edge; later input changes have no effect.
- State machine: IDLE / MUL.
  - IDLE → MUL on an accepted MUL request.
  - MUL → IDLE after iteration 32.
  - Single-cycle ops stay in IDLE.
- Arithmetic rules:
  - ADD: C = carry out of bit 31.
  - SUB/RSB/CMP: computed as X + ~Y + 1; C = carry out, so C=1 means no borrow.
  - V = signed overflow: operands of the same sign (after inversion for subtract) producing a result of the opposite sign.
  - N = `Result[31]`; Z = (`Result` == 0).
- Flag update (only when `SetFlags`=1):
  - ADD/SUB/RSB/CMP: update N, Z, C, V.
  - Logic ops, MOV, MVN, MUL: update N and Z only; C and V hold.
- CMP: `Result` is loaded with A−B like SUB. The downstream stage suppresses the register write.
- MUL datapath: 32-bit accumulator, multiplicand register shifted left, multiplier register shifted right; one bit is consumed per iteration. Overflow beyond bit 31 is discarded.

## Timing
- Reset values: `Result`=0, `Flags`=4'b0000, `Done`=0, `Busy`=0, state IDLE.
  - Reset takes effect immediately on `reset_n` falling, independent of `clk`.
  - Reset during MUL aborts the operation; no `Done` follows.
- Single-cycle op accepted at edge k:
  - `Result`, `Flags` and `Done`=1 are valid after edge k.
  - `Done` returns to 0 after edge k+1 unless another op is accepted at k+1.
  - Back-to-back ops are accepted every cycle.
- MUL accepted at edge k:
  - `Busy`=1 after edges k through k+31.
  - Iterations run at edges k+1 … k+32.
  - At edge k+32: `Result` and `Flags` load, `Done`=1, `Busy`=0.
  - Earliest next acceptance is edge k+33.
- `Start`=1 while `Busy`=1 is dropped silently. It is not queued.
- `Result` and `Flags` hold their values between completions. During MUL they keep the previous operation's values.
- `SetFlags` is captured at acceptance, not sampled at completion.

## Test plan
- ADD, A=0x7FFFFFFF, B=0x00000001, SetFlags=1 → `Result`=0x80000000, `Flags`=1001, `Done` high exactly one cycle after the Start edge.
- SUB, A=5, B=5, SetFlags=1 → `Result`=0, `Flags`=0110. Then RSB, A=6, B=5 → `Result`=0xFFFFFFFF, `Flags`=1000.
- MUL, A=0xFFFFFFFF, B=0xFFFFFFFF, SetFlags=1 → `Busy` high for exactly 32 cycles, `Done` at edge k+32, `Result`=0x00000001, N=0, Z=0, C/V unchanged. Also MUL 12×10 → 120.
- Start with ADD asserted at edges k+5 and k+31 during a MUL → both ignored; the only completion is the MUL; `Result` holds its old value until k+32.
- Assert `reset_n`=0 asynchronously mid-MUL (cycle k+10) → `Result`=0, `Flags`=0, `Busy`=0 immediately; no `Done` pulse after release.
- ORR 0xF0F00000 | 0x0000000F with SetFlags=0 after a flag-setting CMP → `Result`=0xF0F0000F, `Flags` unchanged from the CMP.
